divider_ctrl: RTL and testbench
===============================

Name: divider_ctrl

Overview:
- Run-time controller for the counter-based clock divider: it enables and stops the divided clock and schedules divide-ratio changes without glitches.
- Ratio updates arrive on a valid/ready handshake. They are applied only at a full-period boundary, so no runt high or low pulse ever appears on clk_out.
- Sits between a register/config master and the clock-consuming logic. Everything runs in one sys_clock domain.

Parameters:
- CNT_W, 8, width of the divide-ratio field and of the counter.
- DIV_DEFAULT, 8'd5, divide ratio loaded at reset. Half-period = DIV+1 sys_clock cycles.

Ports:
- sys_clock  in  1  system clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  CNT_W  ratio; half-period = cfg_div+1 cycles; 0 is legal (divide by 2).
- cfg_ready  out  1  controller can accept a ratio.
- cfg_done  out  1  one-cycle pulse when a ratio has been applied.
- clk_out  out  1  divided clock (registered).
- clk_tick  out  1  one-cycle pulse in every cycle clk_out shows a new value.
- busy  out  1  high whenever the controller is not in STOP.

Behaviour:
- Reset values:
  - state=STOP, cnt=0, div_reg=DIV_DEFAULT, pend=0.
  - clk_out=0, clk_tick=0, cfg_ready=1, cfg_done=0, busy=0.
  - A reset mid-operation aborts immediately to these values and drops any pending ratio.
- Counter in RUN/DRAIN:
  - cnt counts 0..div_reg, then wraps to 0.
  - Toggle event = (cnt==div_reg); clk_out inverts at that edge.
  - clk_tick is registered and high the cycle after the event, i.e. aligned with the new clk_out value.
  - Falling toggle = a toggle event while clk_out==1.
- STOP:
  - clk_out held 0, cnt held 0, busy=0.
  - en=1 -> RUN next edge. clk_out rises after div_reg+1 RUN cycles.
- RUN:
  - free-running counter.
  - en=0 with clk_out==0 -> STOP next edge, cnt<=0. The low phase simply lengthens; no runt pulse.
  - en=0 with clk_out==1 -> DRAIN.
- DRAIN:
  - Counting continues until the falling toggle; then clk_out<=0 -> STOP.
  - en=1 while in DRAIN -> back to RUN with no disturbance to cnt or clk_out.
- Config handshake:
  - Accept when cfg_valid & cfg_ready. pend_div<=cfg_div, pend<=1, cfg_ready<=0 next edge.
  - In STOP: applied the next edge (div_reg<=pend_div, pend<=0); cfg_done pulses that cycle.
  - In RUN/DRAIN: applied at the first falling toggle evaluated with pend already set. At that edge div_reg<=pend_div and cnt<=0. A ratio accepted in the same cycle as a falling toggle waits for the following one.
  - cfg_done pulses in the cycle after application; cfg_ready returns to 1 in that same cycle.
  - Only one ratio is outstanding at a time; there is no queue.
- A falling toggle that both applies a ratio and ends DRAIN does both at the same edge.
- Width: cnt and div_reg are CNT_W bits. Compare for equality only; no overflow is possible because cnt never exceeds div_reg.

Decomposition:
- Package divider_pkg:
  - state enum {STOP, RUN, DRAIN}.
  - CNT_W default and DIV_DEFAULT constant.
- Sub-module divider_core holds cnt, the toggle and clk_tick.
  - Inputs: run, load, load_div.
  - Outputs: clk_out, tick, fall_evt (combinational falling-toggle indication).
- divider_ctrl holds the FSM and the config handshake.

Test Plan:
- Reset, en=1, default div 5 -> clk_out low 6 cycles then high 6 cycles, period 12. clk_tick pulses every 6 cycles. busy=1.
- In RUN, write cfg_div=2 mid high phase -> cfg_ready drops next cycle. Old ratio continues until the falling toggle. Then the half-period is 3 cycles; cfg_done pulses once; cfg_ready=1.
- Drop en while clk_out=1 at cnt=1 (div 5) -> high phase completes its 6 cycles, clk_out=0, then STOP (busy=0). Reassert en during DRAIN -> no STOP, period unchanged.
- cfg_div=0 written in STOP -> applied next cycle. en=1 -> clk_out toggles every cycle (sys_clock/2).
- Ratio accepted in the same cycle as a falling toggle (div 3 -> 7) -> one more full period at div 3, then div 7 (half-period 8).
- Assert sys_rst_n=0 asynchronously mid-high with a ratio pending -> clk_out=0 immediately. After release, div=5 and no cfg_done pulse.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and default sizing for the run-time clock divider controller.
package divider_pkg;

    localparam int CNT_W_DEF = 8;
    localparam logic [CNT_W_DEF-1:0] DIV_DEF = 8'd5;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/divider_core.sv
// Counter and output toggle of the divided clock; half-period is div_q+1 sys_clock cycles.
module divider_core
    import divider_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(DIV_DEF)
) (
    input  logic             sys_clock,
    input  logic             sys_rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             clk_out,
    output logic             tick,
    output logic             fall_evt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q;
    logic             wrap;

    assign wrap     = (cnt_q == div_q);
    assign fall_evt = wrap && clk_q;

    // A load only ever lands on a falling toggle or in STOP, so forcing the
    // output low and restarting the count is always glitch-free.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        clk_d = clk_q;
        if (load) begin
            div_d = load_div;
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (!run) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            clk_d = !clk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_DEFAULT;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            clk_q  <= clk_d;
            tick_q <= (clk_d != clk_q);
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/divider_ctrl.sv
// Run/stop sequencing and glitch-free ratio hand-over for the counter-based clock divider.
module divider_ctrl
    import divider_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(DIV_DEF)
) (
    input  logic             sys_clock,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             clk_out,
    output logic             clk_tick,
    output logic             busy
);

    state_t           state_q;
    logic             busy_q;
    logic             pend_q;
    logic             done_q;
    logic [CNT_W-1:0] pend_div_q;

    logic fall_evt;
    logic stop_now;
    logic run;
    logic accept;
    logic apply;

    // Stopping is only safe while the output is low or at the edge that takes it low.
    assign stop_now = (state_q != STOP) && !en && (!clk_out || fall_evt);
    assign run      = (state_q != STOP) && !stop_now;
    assign accept   = cfg_valid && !pend_q;
    assign apply    = pend_q && ((state_q == STOP) || fall_evt);

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= STOP;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                STOP: begin
                    if (en) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (stop_now) begin
                        state_q <= STOP;
                        busy_q  <= 1'b0;
                    end else if (en) begin
                        state_q <= RUN;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
            endcase
        end
    end

    // Single-entry holding register; a ratio offered while one is pending is back-pressured.
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                pend_q     <= 1'b1;
                pend_div_q <= cfg_div;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
            done_q <= apply;
        end
    end

    divider_core #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_core (
        .sys_clock (sys_clock),
        .sys_rst_n (sys_rst_n),
        .run       (run),
        .load      (apply),
        .load_div  (pend_div_q),
        .clk_out   (clk_out),
        .tick      (clk_tick),
        .fall_evt  (fall_evt)
    );

    assign cfg_ready = !pend_q;
    assign cfg_done  = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed bench for divider_ctrl: waveform shapes, ratio hand-over, drain and reset abort.
module tb_divider_ctrl;

    logic       sys_clock;
    logic       sys_rst_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_done;
    logic       clk_out;
    logic       clk_tick;
    logic       busy;

    int total = 0;
    int bad   = 0;

    divider_ctrl dut (
        .sys_clock (sys_clock),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .clk_out   (clk_out),
        .clk_tick  (clk_tick),
        .busy      (busy)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [7:0] d);
        en        = e;
        cfg_valid = v;
        cfg_div   = d;
    endtask

    // Each pattern character is the expected value at one successive falling sys_clock edge.
    task automatic sampleSeq(input string tag, input string clkPat, input string tickPat,
                             input string donePat);
        for (int i = 0; i < clkPat.len(); i++) begin
            @(negedge sys_clock);
            checkOutput($sformatf("%s.clk[%0d]", tag, i), clk_out, clkPat[i] == "1");
            checkOutput($sformatf("%s.tick[%0d]", tag, i), clk_tick, tickPat[i] == "1");
            checkOutput($sformatf("%s.done[%0d]", tag, i), cfg_done, donePat[i] == "1");
        end
    endtask

    task automatic resetDut();
        sys_rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge sys_clock);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0);
        @(negedge sys_clock);
        checkOutput("rst.clk", clk_out, 1'b0);
        checkOutput("rst.tick", clk_tick, 1'b0);
        checkOutput("rst.ready", cfg_ready, 1'b1);
        checkOutput("rst.done", cfg_done, 1'b0);
        checkOutput("rst.busy", busy, 1'b0);
        @(negedge sys_clock);
        sys_rst_n = 1'b1;

        // Default ratio 5: six cycles low, six high.
        applyStimulus(1'b1, 1'b0, 8'd0);
        sampleSeq("run5", "000000111111000000111", "000000100000100000100",
                  "000000000000000000000");
        checkOutput("run5.busy", busy, 1'b1);
        checkOutput("run5.ready", cfg_ready, 1'b1);

        // Ratio 2 offered mid-high; takes effect at the falling toggle.
        applyStimulus(1'b1, 1'b1, 8'd2);
        @(negedge sys_clock);
        applyStimulus(1'b1, 1'b0, 8'd2);
        checkOutput("cfg2.ready_low", cfg_ready, 1'b0);
        sampleSeq("cfg2a", "110", "001", "001");
        checkOutput("cfg2.ready_back", cfg_ready, 1'b1);
        sampleSeq("cfg2b", "001110", "001001", "000000");

        // Drain: en dropped at cnt=1 of the high phase.
        resetDut();
        applyStimulus(1'b1, 1'b0, 8'd0);
        sampleSeq("drn.start", "00000011", "00000010", "00000000");
        applyStimulus(1'b0, 1'b0, 8'd0);
        sampleSeq("drn.high", "1111", "0000", "0000");
        checkOutput("drn.busy_high", busy, 1'b1);
        sampleSeq("drn.stop", "0000", "1000", "0000");
        checkOutput("drn.busy_stop", busy, 1'b0);

        // Drain cancelled by re-asserting en.
        applyStimulus(1'b1, 1'b0, 8'd0);
        sampleSeq("rea.start", "00000011", "00000010", "00000000");
        applyStimulus(1'b0, 1'b0, 8'd0);
        sampleSeq("rea.drain", "11", "00", "00");
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("rea.busy_drain", busy, 1'b1);
        sampleSeq("rea.run", "110000001", "001000001", "000000000");
        checkOutput("rea.busy_run", busy, 1'b1);

        // Ratio 0 written in STOP: divide by two.
        resetDut();
        applyStimulus(1'b0, 1'b1, 8'd0);
        @(negedge sys_clock);
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkOutput("div0.ready_low", cfg_ready, 1'b0);
        checkOutput("div0.done_wait", cfg_done, 1'b0);
        @(negedge sys_clock);
        checkOutput("div0.done", cfg_done, 1'b1);
        checkOutput("div0.ready_back", cfg_ready, 1'b1);
        checkOutput("div0.busy_stop", busy, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0);
        sampleSeq("div0.run", "01010101", "01111111", "00000000");
        checkOutput("div0.busy_run", busy, 1'b1);

        // Ratio 3 -> 7 accepted exactly on a falling toggle: one more period at 3 first.
        resetDut();
        applyStimulus(1'b0, 1'b1, 8'd3);
        @(negedge sys_clock);
        applyStimulus(1'b0, 1'b0, 8'd3);
        @(negedge sys_clock);
        checkOutput("d37.done3", cfg_done, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd3);
        sampleSeq("d37.p3", "00001111", "00001000", "00000000");
        applyStimulus(1'b1, 1'b1, 8'd7);
        @(negedge sys_clock);
        applyStimulus(1'b1, 1'b0, 8'd7);
        checkOutput("d37.fall_clk", clk_out, 1'b0);
        checkOutput("d37.fall_tick", clk_tick, 1'b1);
        checkOutput("d37.ready_low", cfg_ready, 1'b0);
        checkOutput("d37.no_early_done", cfg_done, 1'b0);
        sampleSeq("d37.extra3", "0001111", "0001000", "0000000");
        sampleSeq("d37.apply", "00", "10", "10");
        checkOutput("d37.ready_back", cfg_ready, 1'b1);
        sampleSeq("d37.p7", "000000111111110", "000000100000001", "000000000000000");

        // Asynchronous reset mid-high with a ratio pending.
        resetDut();
        applyStimulus(1'b1, 1'b0, 8'd0);
        sampleSeq("ar.start", "00000011", "00000010", "00000000");
        applyStimulus(1'b1, 1'b1, 8'd2);
        @(negedge sys_clock);
        applyStimulus(1'b1, 1'b0, 8'd2);
        checkOutput("ar.ready_low", cfg_ready, 1'b0);
        checkOutput("ar.clk_high", clk_out, 1'b1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("ar.clk", clk_out, 1'b0);
        checkOutput("ar.busy", busy, 1'b0);
        checkOutput("ar.ready", cfg_ready, 1'b1);
        checkOutput("ar.tick", clk_tick, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge sys_clock);
        sys_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd0);
        sampleSeq("ar.after", "0000001111110", "0000001000001", "0000000000000");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
